// File: rtl/out_requant.sv
// Output requantizer: reads 4x16-bit partial sums, round-shifts and saturates to 4x8-bit, writes packed words.
// Optional macro RELU_EN clamps negative results to zero after saturation.
module out_requant #(
  parameter int LANES = 4,
  parameter int IW    = 16,
  parameter int OW    = 8,
  parameter int AW    = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [11:0]           MNT,
  input  logic [3:0]            SHIFT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  EN_O,
  output logic                  RW_O,
  output logic [AW-1:0]         ADDR_O,
  input  logic [LANES*IW-1:0]   RDATA_O,
  output logic                  EN_D,
  output logic                  WE_D,
  output logic [AW-1:0]         ADDR_D,
  output logic [LANES*OW-1:0]   WDATA_D
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic signed [IW:0] SatMax = (IW+1)'(2**(OW-1) - 1);
  localparam logic signed [IW:0] SatMin = (IW+1)'(-(2**(OW-1)));

  state_t               state_q;
  logic [AW-1:0]        num_q;
  logic [3:0]           shift_q;
  logic                 busy_q, done_q, enO_q, enD_q;
  logic [AW-1:0]        addrO_q, addrD_q;
  logic                 rdv_q;
  logic [AW-1:0]        rdAddr_q;
  logic [LANES*OW-1:0]  wdata_q, wdata_d;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive extreme.
  function automatic logic [OW-1:0] requant(input logic [IW-1:0] x, input logic [3:0] sh);
    logic signed [IW:0] acc;
    logic signed [IW:0] rnd;
    logic [OW-1:0]      sat;
    acc = $signed({x[IW-1], x});
    rnd = '0;
    if (sh != 4'd0) rnd[sh - 4'd1] = 1'b1;
    acc = (acc + rnd) >>> sh;
    if (acc > SatMax)      sat = SatMax[OW-1:0];
    else if (acc < SatMin) sat = SatMin[OW-1:0];
    else                   sat = acc[OW-1:0];
`ifdef RELU_EN
    if (sat[OW-1]) sat = '0;
`else
`endif
    return sat;
  endfunction

  always_comb begin
    wdata_d = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata_d[i*OW +: OW] = requant(RDATA_O[i*IW +: IW], shift_q);
    end
  end

  // DONE is registered from FIN, so DRAIN needs only one cycle for the last write to land in FIN.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      num_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enO_q   <= 1'b0;
      addrO_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            num_q   <= AW'(MNT[11:8]);
            shift_q <= SHIFT;
            busy_q  <= 1'b1;
            if (MNT[11:8] == 4'd0) begin
              state_q <= FIN;
            end else begin
              state_q <= READ;
              enO_q   <= 1'b1;
              addrO_q <= '0;
            end
          end
        end
        READ: begin
          if (addrO_q == num_q - AW'(1)) begin
            enO_q   <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addrO_q <= addrO_q + AW'(1);
          end
        end
        DRAIN: state_q <= FIN;
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rdv_q    <= 1'b0;
      rdAddr_q <= '0;
      enD_q    <= 1'b0;
      addrD_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rdv_q    <= enO_q;
      rdAddr_q <= addrO_q;
      enD_q    <= rdv_q;
      if (rdv_q) begin
        addrD_q <= rdAddr_q;
        wdata_q <= wdata_d;
      end
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign EN_O    = enO_q;
  assign RW_O    = 1'b0;
  assign ADDR_O  = addrO_q;
  assign EN_D    = enD_q;
  assign WE_D    = enD_q;
  assign ADDR_D  = addrD_q;
  assign WDATA_D = wdata_q;

endmodule

// File: tb/tb_out_requant.sv
// Directed bench for out_requant: per-cycle checks of read/write timing, packed data, DONE and reset.
module tb_out_requant;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START;
  logic [11:0] MNT;
  logic [3:0]  SHIFT;
  logic        BUSY, DONE, EN_O, RW_O, EN_D, WE_D;
  logic [3:0]  ADDR_O, ADDR_D;
  logic [63:0] RDATA_O;
  logic [31:0] WDATA_D;

  logic [63:0] mem [16];
  logic [31:0] expWord [16];
  int checks = 0;
  int errors = 0;

`ifdef RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  out_requant dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT), .SHIFT(SHIFT),
    .BUSY(BUSY), .DONE(DONE), .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
    .RDATA_O(RDATA_O), .EN_D(EN_D), .WE_D(WE_D), .ADDR_D(ADDR_D), .WDATA_D(WDATA_D)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (EN_O) RDATA_O <= mem[ADDR_O];
  end

  function automatic logic [63:0] pack4(input int l3, input int l2, input int l1, input int l0);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses START from a negedge, then checks every cycle until DONE or a 40-cycle limit.
  task automatic applyStimulus(input int num, input logic [3:0] sh, input int reStart);
    int cyc, doneCyc, expDone;
    logic expRd, expWr;
    expDone = (num == 0) ? 2 : num + 3;
    MNT   = 12'(num << 8);
    SHIFT = sh;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    MNT   = 12'hA00;
    cyc = 1;
    doneCyc = 0;
    while (doneCyc == 0 && cyc <= 40) begin
      expRd = (num > 0) && (cyc <= num);
      expWr = (num > 0) && (cyc >= 3) && (cyc <= num + 2);
      checkOutput($sformatf("EN_O n%0d c%0d", num, cyc), 64'(EN_O), 64'(expRd));
      checkOutput($sformatf("EN_D n%0d c%0d", num, cyc), 64'(EN_D & WE_D), 64'(expWr));
      checkOutput($sformatf("BUSY n%0d c%0d", num, cyc), 64'(BUSY), 64'(cyc < expDone));
      checkOutput($sformatf("DONE n%0d c%0d", num, cyc), 64'(DONE), 64'(cyc == expDone));
      if (expRd) begin
        checkOutput($sformatf("ADDR_O n%0d c%0d", num, cyc), 64'(ADDR_O), 64'(cyc - 1));
        checkOutput($sformatf("RW_O n%0d c%0d", num, cyc), 64'(RW_O), 64'd0);
      end
      if (expWr) begin
        checkOutput($sformatf("ADDR_D n%0d c%0d", num, cyc), 64'(ADDR_D), 64'(cyc - 3));
        checkOutput($sformatf("WDATA_D n%0d c%0d", num, cyc), 64'(WDATA_D), 64'(expWord[cyc - 3]));
      end
      if (DONE) doneCyc = cyc;
      START = (cyc == reStart);
      if (cyc == reStart) MNT = 12'hF00;
      SHIFT = ~sh;
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    checkOutput($sformatf("done cycle n%0d", num), 64'(doneCyc), 64'(expDone));
  endtask

  initial begin
    int activity;
    RSTN = 1'b0; START = 1'b0; MNT = '0; SHIFT = '0; RDATA_O = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      expWord[i] = '0;
    end
    #12;
    checkOutput("reset ctl", 64'({BUSY, DONE, EN_O, RW_O, EN_D, WE_D}), 64'd0);
    checkOutput("reset addr/data", {24'd0, ADDR_O, ADDR_D, WDATA_D}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);

    // Saturation at shift 0.
    mem[0] = pack4(-5, -300, 300, 100);
    expWord[0] = Relu ? 32'h00007F64 : 32'hFB807F64;
    applyStimulus(1, 4'd0, 0);

    // Rounding at shift 2, including both saturation rails.
    mem[0] = pack4(-9, -10, 9, 10);
    mem[1] = pack4(32767, -32768, 509, 505);
    expWord[0] = Relu ? 32'h00000203 : 32'hFEFE0203;
    expWord[1] = Relu ? 32'h7F007F7E : 32'h7F807F7E;
    applyStimulus(2, 4'd2, 0);

    // Shift 1 rounding of small and extreme values.
    mem[0] = pack4(255, -4, 3, -3);
    mem[1] = pack4(-32768, 32767, 1, -1);
    expWord[0] = Relu ? 32'h7F000200 : 32'h7FFE02FF;
    expWord[1] = Relu ? 32'h007F0100 : 32'h807F0100;
    applyStimulus(2, 4'd1, 0);

    // Maximum shift.
    mem[0] = pack4(-32768, 16384, 32767, 16383);
    expWord[0] = Relu ? 32'h00010100 : 32'hFF010100;
    applyStimulus(1, 4'd15, 0);

    // Full-length back-to-back job.
    for (int i = 0; i < 16; i++) begin
      mem[i] = pack4(-128 - i, i + 100, -i, i);
      expWord[i] = Relu ? {8'h00, 8'(i + 100), 8'h00, 8'(i)}
                        : {8'h80, 8'(i + 100), 8'(-i), 8'(i)};
    end
    applyStimulus(15, 4'd0, 0);

    applyStimulus(0, 4'd3, 0);

    // START re-pulsed with NUM=15 during READ must be ignored.
    applyStimulus(4, 4'd0, 2);

    // Reset in the middle of a NUM=10 job.
    MNT = 12'hA00; SHIFT = 4'd0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("midjob ADDR_O", 64'({EN_O, ADDR_O}), 64'({1'b1, 4'd4}));
    RSTN = 1'b0;
    #1;
    checkOutput("midjob reset ctl", 64'({BUSY, DONE, EN_O, RW_O, EN_D, WE_D}), 64'd0);
    checkOutput("midjob reset addr/data", {24'd0, ADDR_O, ADDR_D, WDATA_D}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    activity = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (EN_O || EN_D || DONE || BUSY) activity++;
    end
    checkOutput("post-reset quiet", 64'(activity), 64'd0);
    applyStimulus(2, 4'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_requant.md
Name: out_requant

Overview:
- Downstream stage of the MAC array. Reads finished 64-bit partial-sum words (4 lanes x signed 16-bit) from the output SRAM and requantizes each lane to signed 8-bit.
- Requantization is a rounding arithmetic right shift followed by saturation.
- Packs the four 8-bit results into a 32-bit word and writes it to the next layer's input SRAM, so the following layer can start without a software copy.
- Started by a START pulse; signals completion with DONE.

Parameters:
- LANES, 4, elements per SRAM word
- IW, 16, input element width (signed, two's complement)
- OW, 8, output element width (signed, two's complement)
- AW, 4, address width of both SRAMs

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- START  in  1  one-cycle start pulse; honoured only in IDLE
- MNT  in  12  job shape; MNT[11:8] = number of words to convert (NUM)
- SHIFT  in  4  right-shift amount, 0..15
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  one-cycle completion pulse
- EN_O  out  1  output-SRAM enable
- RW_O  out  1  output-SRAM direction; this block drives 0 (read)
- ADDR_O  out  AW  output-SRAM read address
- RDATA_O  in  LANES*IW  output-SRAM read data; valid the cycle after EN_O
- EN_D  out  1  destination-SRAM enable
- WE_D  out  1  destination-SRAM write enable
- ADDR_D  out  AW  destination-SRAM address
- WDATA_D  out  LANES*OW  destination-SRAM write data

Behaviour:
- Reset: asynchronous on RSTN low. State = IDLE. BUSY, DONE, EN_O, RW_O, EN_D and WE_D are 0; ADDR_O, ADDR_D and WDATA_D are 0. Internal counters and pipeline valid bits are cleared.
- Reset mid-job: abandons the job immediately. No further memory accesses are made and no DONE is issued.
- States: IDLE, READ, DRAIN, FIN.
- IDLE:
  - On START, latch NUM = MNT[11:8] and SHIFT.
  - NUM = 0: go to FIN. No memory access occurs.
  - NUM > 0: go to READ with rd_cnt = 0.
- READ, one word per cycle:
  - Drive EN_O = 1, RW_O = 0, ADDR_O = rd_cnt, then increment rd_cnt.
  - When rd_cnt == NUM-1 is issued, go to DRAIN.
- Pipeline, relative to the read issued in cycle c:
  - c+1: RDATA_O valid. The per-lane result is computed combinationally and registered with a valid bit and the write address.
  - c+2: EN_D = WE_D = 1, ADDR_D = same index as ADDR_O, WDATA_D = packed result.
  - Address-issue to write latency is exactly 2 cycles; throughput is 1 word per cycle.
- DRAIN: wait until the last write has been issued (2 cycles), then go to FIN.
- FIN: DONE = 1 for one cycle, BUSY = 0, then go to IDLE.
- Cycles from START to DONE: NUM + 3 for NUM > 0; 2 for NUM = 0.
- Per-lane arithmetic (x = signed 16-bit lane):
  - SHIFT = 0: y = x.
  - SHIFT > 0: y = (x + (1 << (SHIFT-1))) >>> SHIFT. Use a 17-bit intermediate so there is no overflow.
  - Saturate y to [-128, 127].
- Packing: lane i is RDATA_O[16i+15:16i] and maps to WDATA_D[8i+7:8i].
- START while BUSY is ignored, as are MNT and SHIFT changes mid-job.
- Idle outputs: EN_O, EN_D and WE_D are 0 outside active cycles; addresses and data hold their last values.
- Address range: NUM = 15 is the maximum; addresses 0..14 are used and address 15 is never touched.

Optional Feature:
- Macro: RELU_EN.
- Defined: after saturation, any negative lane becomes 0, so outputs are in [0, 127]. Applied per lane with no added latency.
- Undefined: signed saturated results are written unchanged.

Test Plan:
- NUM=1, SHIFT=0, word 0 lanes {100, 300, -300, -5}: expect WDATA_D = {0xFB, 0x80, 0x7F, 0x64} with lane3 in the MSB, written at ADDR_D = 0. With RELU_EN, expect {0x00, 0x00, 0x7F, 0x64}. DONE arrives 4 cycles after START.
- SHIFT=2, lane values {10, 9, -10, -9}: expect {3, 2, -2, -2}, i.e. bytes 0x03, 0x02, 0xFE, 0xFE. SHIFT=1 with -3: expect -1 (0xFF).
- NUM=15 back-to-back: 15 consecutive EN_O cycles at ADDR_O 0..14. Writes follow exactly 2 cycles behind with matching ADDR_D, no gaps. DONE at cycle 18.
- NUM=0: no EN_O or EN_D activity; DONE pulses 2 cycles after START.
- START re-pulsed during READ with a different MNT: ignored; the original job completes with the original NUM.
- RSTN low for 1 cycle at READ cycle 5 of a NUM=10 job: all outputs are 0 immediately and no DONE is issued. A new START afterwards runs normally from ADDR_O = 0.
